t_param_chk: RTL

T_PARAM_CHK -- requirements
Module: t_param_chk

---
 rtl/t_param_chk_if.sv | 28 ++
 rtl/t_param_chk.sv | 111 +++++++++++
 2 files changed

// File: rtl/t_param_chk_if.sv
// Producer/checker bundle for t_param_chk.
// Master drives the samples; slave reports run status.
interface t_param_chk_if #(
  parameter int X = 1
);
  logic         start;
  logic         in_valid;
  logic [4:0]   par;
  logic [X:0]   varwidth;
  logic         busy;
  logic         done;
  logic         fail;
  logic [3:0]   err_count;
  logic [7:0]   sample_count;
  logic [4:0]   first_bad;

  modport master (
    output start, in_valid, par, varwidth,
    input  busy, done, fail,
    input  err_count, sample_count, first_bad
  );

  modport slave (
    input  start, in_valid, par, varwidth,
    output busy, done, fail,
    output err_count, sample_count, first_bad
  );
endinterface

// File: rtl/t_param_chk.sv
// Checks a producer's parameter-derived outputs against
// expected constants over a fixed number of valid samples.
module t_param_chk #(
  parameter int X       = 1,
  parameter int EXP_PAR = 5,
  parameter int EXP_VW  = 0,
  parameter int SETTLE  = 2,
  parameter int CHECKS  = 8
) (
  input logic          clk,
  input logic          reset_l,
  t_param_chk_if.slave bus
);

  localparam logic [4:0] EXP_P  = EXP_PAR[4:0];
  localparam logic [X:0] EXP_V  = EXP_VW[X:0];
  localparam logic [3:0] SET_LD = 4'(SETTLE - 1);
  localparam logic [7:0] CHK_N  = 8'(CHECKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  state_t     state, state_n;
  logic [3:0] settle_q, settle_n;
  logic [3:0] err_q, err_n;
  logic [7:0] cnt_q, cnt_n;
  logic [4:0] bad_q, bad_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic       fail_q, fail_n;
  logic       clr;
  logic       mism;

  assign mism = (bus.par != EXP_P) ||
                (bus.varwidth != EXP_V);

  always_comb begin
    state_n  = state;
    settle_n = settle_q;
    err_n    = err_q;
    cnt_n    = cnt_q;
    bad_n    = bad_q;
    clr      = 1'b0;
    unique case (state)
      S_IDLE: clr = bus.start;
      S_SETTLE: begin
        if (settle_q == 4'd0) state_n = S_CHECK;
        else settle_n = settle_q - 4'd1;
      end
      S_CHECK: begin
        if (bus.in_valid) begin
          cnt_n = cnt_q + 8'd1;
          if (mism) begin
            if (err_q != 4'hf) err_n = err_q + 4'd1;
            // err_q==0 marks the first mismatch of the run
            if (err_q == 4'd0) bad_n = bus.par;
          end
          if (cnt_n == CHK_N)
            state_n = (err_n == 4'd0) ? S_PASS : S_FAIL;
        end
      end
      S_PASS, S_FAIL: clr = bus.start;
      default: state_n = S_IDLE;
    endcase
    if (clr) begin
      state_n  = S_SETTLE;
      settle_n = SET_LD;
      err_n    = 4'd0;
      cnt_n    = 8'd0;
      bad_n    = 5'd0;
    end
    busy_n = (state_n == S_SETTLE) || (state_n == S_CHECK);
    done_n = (state_n == S_PASS) || (state_n == S_FAIL);
    fail_n = (state_n == S_FAIL);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= S_IDLE;
      settle_q <= 4'd0;
      err_q    <= 4'd0;
      cnt_q    <= 8'd0;
      bad_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state    <= state_n;
      settle_q <= settle_n;
      err_q    <= err_n;
      cnt_q    <= cnt_n;
      bad_q    <= bad_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      fail_q   <= fail_n;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.err_count    = err_q;
  assign bus.sample_count = cnt_q;
  assign bus.first_bad    = bad_q;

endmodule
